// File: rtl/imem_resp.sv
// Instruction-memory responder with a fixed request-to-response latency.
// A fetch request is accepted in IDLE, counted down in BUSY, and answered with a
// one-cycle done pulse carrying the registered instruction word. Flush cancels.
// Optional feature: define IMEM_ALIGN_CHECK_EN to flag odd fetch addresses
// (misalign=1, NOP returned, array not read) instead of reading the containing word.
module imem_resp #(
  parameter int unsigned LATENCY    = 2,  // edges from accept to done; 1..15
  parameter int unsigned DEPTH_LOG2 = 8   // log2 of the word count
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [15:0] addr_i,
  input  logic        flush_i,
  output logic        rdy_o,
  output logic        done_o,
  output logic [15:0] instr_o,
  output logic        misalign_o,
  input  logic        load_en_i,
  input  logic [15:0] load_addr_i,
  input  logic [15:0] load_data_i
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam logic [15:0] NopInstr = 16'h0800;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    done_q;
  logic [15:0]             instr_q;
  logic [15:0]             mem_q [Depth];
  logic                    accept;

`ifdef IMEM_ALIGN_CHECK_EN
  logic                    odd_q;
  logic                    misalign_q;
`endif

  // Upper address bits wrap; low bit is only meaningful with the align check.
  logic unused_addr;
  assign unused_addr = ^{addr_i[15:DEPTH_LOG2+1], addr_i[0],
                         load_addr_i[15:DEPTH_LOG2+1], load_addr_i[0]};

  // Flush outranks a new request.
  assign accept = req_i & (state_q == StIdle) & ~flush_i;

  // Loader port; the response read below sees the pre-write word on a shared edge.
  always_ff @(posedge clk) begin
    if (load_en_i) begin
      mem_q[load_addr_i[DEPTH_LOG2:1]] <= load_data_i;
    end
  end

  // Request FSM: accept, count down, respond (or cancel on flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      instr_q    <= NopInstr;
`ifdef IMEM_ALIGN_CHECK_EN
      odd_q      <= 1'b0;
      misalign_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= addr_i[DEPTH_LOG2:1];
`ifdef IMEM_ALIGN_CHECK_EN
            odd_q   <= addr_i[0];
`endif
            cnt_q   <= 4'(LATENCY);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            done_q  <= 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
            if (odd_q) begin
              instr_q    <= NopInstr;
              misalign_q <= 1'b1;
            end else begin
              instr_q    <= mem_q[idx_q];
              misalign_q <= 1'b0;
            end
`else
            instr_q <= mem_q[idx_q];
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdy_o   = (state_q == StIdle);
  assign done_o  = done_q;
  assign instr_o = instr_q;
`ifdef IMEM_ALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: a timestamp-based reference model predicts each
// response; a negedge monitor compares DUT outputs and pops the scoreboard on done.
module tb_imem_resp;

  localparam int Lat = 2;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [15:0] load_addr = 16'h0;
  logic [15:0] load_data = 16'h0;
  logic        rdy, done, misalign;
  logic [15:0] instr;

  imem_resp #(.LATENCY(Lat), .DEPTH_LOG2(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .addr_i     (addr),
    .flush_i    (flush),
    .rdy_o      (rdy),
    .done_o     (done),
    .instr_o    (instr),
    .misalign_o (misalign),
    .load_en_i  (load_en),
    .load_addr_i(load_addr),
    .load_data_i(load_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endfunction

  // Reference model state
  logic [15:0] ref_mem [256];
  bit          pend = 1'b0;
  int          resp_at = 0;
  int          pidx = 0;
  bit          podd = 1'b0;
  int          mcyc = 0;
  logic        exp_rdy = 1'b1;
  logic        exp_done = 1'b0;
  logic [15:0] exp_instr = 16'h0800;
  logic        exp_mis = 1'b0;

  typedef struct packed {logic [15:0] instr; logic mis;} resp_t;
  resp_t sb_q[$];

  // Model: a pending request answers exactly Lat edges after its accept edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend      = 1'b0;
      exp_rdy   = 1'b1;
      exp_done  = 1'b0;
      exp_instr = 16'h0800;
      exp_mis   = 1'b0;
    end else begin
      mcyc++;
      exp_done = 1'b0;
      if (pend && flush) begin
        pend = 1'b0;
      end else if (pend && mcyc == resp_at) begin
        if (AlignChk && podd) begin
          exp_instr = 16'h0800;
          exp_mis   = 1'b1;
        end else begin
          exp_instr = ref_mem[pidx];
          exp_mis   = 1'b0;
        end
        exp_done = 1'b1;
        pend     = 1'b0;
        sb_q.push_back({exp_instr, exp_mis});
      end else if (!pend && req && !flush) begin
        pend    = 1'b1;
        resp_at = mcyc + Lat;
        pidx    = int'((addr >> 1) % 256);
        podd    = addr[0];
      end
      if (load_en) ref_mem[int'((load_addr >> 1) % 256)] = load_data;
      exp_rdy = !pend;
    end
  end

  // Monitor
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (!rst) begin
      check("rdy", 32'(rdy), 32'(exp_rdy));
      check("done", 32'(done), 32'(exp_done));
      check("instr", 32'(instr), 32'(exp_instr));
      check("misalign", 32'(misalign), 32'(exp_mis));
      if (done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done at %0t: got=done want=no_done", $time);
        end else begin
          r = sb_q.pop_front();
          check("sb_instr", 32'(instr), 32'(r.instr));
          check("sb_misalign", 32'(misalign), 32'(r.mis));
        end
      end
    end
  end

  task automatic drive(input bit r, input logic [15:0] a, input bit f, input bit le,
                       input logic [15:0] la, input logic [15:0] ld);
    @(negedge clk);
    req = r; addr = a; flush = f; load_en = le; load_addr = la; load_data = ld;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_instr", 32'(instr), 32'h0800);
    check("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Preload every word, then the directed words
    for (int i = 0; i < 256; i++) drive(1'b0, 16'h0, 1'b0, 1'b1, 16'(i * 2), 16'($urandom));
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0000, 16'hC001);
    drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0002, 16'hD002);
    idle(1);

    // Single request
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(4);
    // Held request, address switched mid-stream
    repeat (3) drive(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(4);
    // Flush the cycle after accept
    drive(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0);
    idle(3);
    // Address wrap
    drive(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(4);
    // Flush on the response edge suppresses done
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0, 16'h0);
    idle(3);
    // Load on the response edge: old word returned, new word on next fetch
    drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 16'hBEEF);
    idle(3);
    drive(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(4);
    // Odd address
    drive(1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(4);

    // Async reset mid-BUSY, asserted while clk is low
    drive(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_instr", 32'(instr), 32'h0800);
    check("midrst_misalign", 32'(misalign), 32'd0);
    @(negedge clk) rst = 1'b0;
    idle(5);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(bit'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0, 16'($urandom), 16'($urandom));
    end
    idle(Lat + 5);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
